// File: rtl/led_frame_buffer.sv
// Double-buffered LED frame store: writer fills the back bank, bank swap deferred to the next frame boundary.
// Latency: accepted writes land in the back bank at the sampling edge; o_rows follows the bank select with no extra register stage.
// Backpressure: o_wr_ready low during CLEAR/PENDING; writes issued then are dropped and flagged on o_wr_err one cycle later.
module led_frame_buffer #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_ROWS_WIDTH = 2,
    parameter int NUM_COLS       = 8
) (
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic                      i_wr_en,
    input  logic [NUM_ROWS_WIDTH-1:0] i_wr_row,
    input  logic [NUM_COLS-1:0]       i_wr_data,
    input  logic                      i_swap_req,
    input  logic                      i_clear,
    input  logic                      i_frame_start,
    output logic [NUM_COLS-1:0]       o_rows [0:NUM_ROWS-1],
    output logic                      o_wr_ready,
    output logic                      o_swap_pending,
    output logic                      o_swap_done,
    output logic                      o_wr_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        PENDING = 2'd2
    } state_t;

    // Extra bit so NUM_ROWS itself is representable when it equals 2^NUM_ROWS_WIDTH.
    localparam logic [NUM_ROWS_WIDTH:0]   ROW_LIMIT = (NUM_ROWS_WIDTH+1)'(NUM_ROWS);
    localparam logic [NUM_ROWS_WIDTH-1:0] LAST_ROW  = NUM_ROWS_WIDTH'(NUM_ROWS - 1);

    state_t                    state;
    logic                      front_sel;   // 0: bank0 is displayed, 1: bank1 is displayed
    logic [NUM_ROWS_WIDTH-1:0] clr_cnt;

    logic [NUM_COLS-1:0] bank0 [0:NUM_ROWS-1];
    logic [NUM_COLS-1:0] bank1 [0:NUM_ROWS-1];

    logic                      wr_accept;
    logic                      bank_we;
    logic [NUM_ROWS_WIDTH-1:0] bank_addr;
    logic [NUM_COLS-1:0]       bank_dat;

    assign wr_accept = i_wr_en && ({1'b0, i_wr_row} < ROW_LIMIT) && (state == IDLE);

    // Back-bank write port: the clear sweep owns it in CLEAR, otherwise accepted writer data.
    always_comb begin
        bank_we   = 1'b0;
        bank_addr = i_wr_row;
        bank_dat  = i_wr_data;
        if (state == CLEAR) begin
            bank_we   = 1'b1;
            bank_addr = clr_cnt;
            bank_dat  = '0;
        end else if (wr_accept) begin
            bank_we = 1'b1;
        end
    end

    // Bank storage: only the bank not selected for display is ever written.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                bank0[r] <= '0;
                bank1[r] <= '0;
            end
        end else if (bank_we) begin
            if (front_sel) begin
                bank0[bank_addr] <= bank_dat;
            end else begin
                bank1[bank_addr] <= bank_dat;
            end
        end
    end

    // Control FSM with registered status outputs; the bank toggle happens only on a frame boundary.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state          <= IDLE;
            clr_cnt        <= '0;
            front_sel      <= 1'b0;
            o_wr_ready     <= 1'b1;
            o_swap_pending <= 1'b0;
            o_swap_done    <= 1'b0;
            o_wr_err       <= 1'b0;
        end else begin
            o_swap_done <= 1'b0;
            o_wr_err    <= i_wr_en && !wr_accept;
            case (state)
                IDLE: begin
                    // Clear wins over a simultaneous swap request, which is dropped.
                    if (i_clear) begin
                        state      <= CLEAR;
                        clr_cnt    <= '0;
                        o_wr_ready <= 1'b0;
                    end else if (i_swap_req) begin
                        state          <= PENDING;
                        o_wr_ready     <= 1'b0;
                        o_swap_pending <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_ROW) begin
                        state      <= IDLE;
                        o_wr_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                PENDING: begin
                    if (i_frame_start) begin
                        front_sel      <= ~front_sel;
                        state          <= IDLE;
                        o_wr_ready     <= 1'b1;
                        o_swap_pending <= 1'b0;
                        o_swap_done    <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    o_wr_ready     <= 1'b1;
                    o_swap_pending <= 1'b0;
                end
            endcase
        end
    end

    // Front bank presented continuously as the driver's row array.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            o_rows[r] = front_sel ? bank1[r] : bank0[r];
        end
    end

endmodule
